lif_soma: RTL and testbench

LIF_SOMA -- requirements
Module: lif_soma

---
 rtl/snn_pkg.sv | 26 ++
 rtl/dendrite_sum.sv | 22 ++
 rtl/lif_soma.sv | 103 ++++++++++
 tb/tb_lif_soma.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared spiking-neuron definitions: soma FSM states and a width-generic
// saturating adder used by every neuron stage.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRACT   = 2'd2
  } soma_state_e;

  // Adds two signed values and clips the result into the signed range of 'width' bits (width <= 32).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned       width);
    longint sum;
    longint hi;
    longint lo;
    sum = longint'(a) + longint'(b);
    hi  = (longint'(1) <<< (width - 1)) - 1;
    lo  = -hi - 1;
    if (sum > hi)      sum = hi;
    else if (sum < lo) sum = lo;
    return 32'(sum);
  endfunction

endpackage

// File: rtl/dendrite_sum.sv
// Combinational weighted adder: sums the weights of all dendrites that spiked.
// The output is wide enough that S terms of W bits can never overflow.
module dendrite_sum #(
  parameter int S = 4,
  parameter int W = 8
) (
  input  logic        [S-1:0]           dendrite_spike,
  input  logic signed [W-1:0]           weight [S-1:0],
  output logic signed [W+$clog2(S):0]   input_sum
);

  localparam int SW = W + $clog2(S) + 1;

  // NOTE: blocking '=' is correct for a combinational accumulator; clocked state elsewhere uses '<='.
  always_comb begin
    input_sum = '0;
    for (int j = 0; j < S; j++) begin
      if (dendrite_spike[j]) input_sum = input_sum + SW'(weight[j]);
    end
  end

endmodule

// File: rtl/lif_soma.sv
// Leaky integrate-and-fire soma: leaks toward zero, integrates weighted dendrite
// spikes with saturation, fires a one-cycle axon pulse, then sits out a refractory period.
module lif_soma
  import snn_pkg::*;
#(
  parameter int                S         = 4,
  parameter int                W         = 8,
  parameter int                P         = 16,
  parameter logic signed [P-1:0] THRESHOLD = 100,
  parameter int unsigned       LEAK      = 1,
  parameter logic signed [P-1:0] V_RESET   = 0,
  parameter int unsigned       REFRACT   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic        [S-1:0] dendrite_spike,
  input  logic signed [W-1:0] weight [S-1:0],
  output logic                spike_out,
  output logic signed [P-1:0] potential,
  output logic                refractory
);

  localparam int                SW         = W + $clog2(S) + 1;
  localparam int                CW         = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [P:0] LEAK_X     = (P + 1)'(LEAK);
  localparam logic [CW-1:0]     REFRACT_LD = CW'(REFRACT);

  soma_state_e          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic signed [SW-1:0] input_sum;
  logic signed [P:0]    v_x;
  logic signed [P-1:0]  v_l, candidate, pot_nxt;

  dendrite_sum #(.S(S), .W(W)) u_dendrite_sum (
    .dendrite_spike (dendrite_spike),
    .weight         (weight),
    .input_sum      (input_sum)
  );

  // Leak toward zero without crossing it; one extra bit keeps the LEAK compare exact.
  always_comb begin
    v_x = {potential[P-1], potential};
    v_l = '0;
    if (v_x > LEAK_X)       v_l = P'(v_x - LEAK_X);
    else if (v_x < -LEAK_X) v_l = P'(v_x + LEAK_X);
  end

  assign candidate = P'(sat_add(32'(v_l), 32'(input_sum), P));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pot_nxt   = potential;
    unique case (state)
      ST_INTEGRATE: begin
        if (candidate >= THRESHOLD) begin
          state_nxt = ST_FIRE;
          pot_nxt   = V_RESET;
        end else begin
          pot_nxt = candidate;
        end
      end
      ST_FIRE: begin
        pot_nxt = V_RESET;
        if (REFRACT > 0) begin
          state_nxt = ST_REFRACT;
          cnt_nxt   = REFRACT_LD;
        end else begin
          state_nxt = ST_INTEGRATE;
        end
      end
      ST_REFRACT: begin
        // Inputs on the cycle that leaves REFRACT are dropped, not integrated.
        pot_nxt = V_RESET;
        if (cnt <= CW'(1)) begin
          state_nxt = ST_INTEGRATE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = ST_INTEGRATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_INTEGRATE;
      potential  <= '0;
      cnt        <= '0;
      spike_out  <= 1'b0;
      refractory <= 1'b0;
    end else begin
      state      <= state_nxt;
      potential  <= pot_nxt;
      cnt        <= cnt_nxt;
      spike_out  <= (state == ST_INTEGRATE) && (state_nxt == ST_FIRE);
      refractory <= (state_nxt != ST_INTEGRATE);
    end
  end

endmodule

// File: tb/tb_lif_soma.sv
// Self-checking bench for lif_soma: an arithmetic neuron model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lif_soma;

  localparam int S = 4;
  localparam int W = 8;
  localparam int P = 16;
  localparam int THR = 100;
  localparam int LEAK = 1;
  localparam int REFR = 3;
  localparam int VMAX = 32767;
  localparam int VMIN = -32768;

  logic                clk = 1'b0;
  logic                reset;
  logic        [S-1:0] dendrite_spike;
  logic signed [W-1:0] weight [S-1:0];
  logic                spike_out;
  logic signed [P-1:0] potential;
  logic                refractory;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model state: potential, remaining ignored-input cycles, output pulse, refractory flag.
  int m_v = 0;
  int m_busy = 0;
  bit m_spk = 1'b0;
  bit m_ref = 1'b0;

  lif_soma #(
    .S(S), .W(W), .P(P), .THRESHOLD(16'sd100), .LEAK(LEAK), .V_RESET(16'sd0), .REFRACT(REFR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dendrite_spike (dendrite_spike),
    .weight         (weight),
    .spike_out      (spike_out),
    .potential      (potential),
    .refractory     (refractory)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin : model
    int sum;
    int vl;
    int cand;
    if (!reset) begin
      m_v <= 0; m_busy <= 0; m_spk <= 1'b0; m_ref <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      m_v    <= 0;
      m_spk  <= 1'b0;
      m_ref  <= (m_busy > 1);
    end else begin
      sum = 0;
      for (int j = 0; j < S; j++) if (dendrite_spike[j]) sum += int'(weight[j]);
      if (m_v > 0)      vl = (m_v > LEAK) ? m_v - LEAK : 0;
      else if (m_v < 0) vl = (m_v < -LEAK) ? m_v + LEAK : 0;
      else              vl = 0;
      cand = vl + sum;
      if (cand > VMAX) cand = VMAX;
      if (cand < VMIN) cand = VMIN;
      if (cand >= THR) begin
        m_v <= 0; m_spk <= 1'b1; m_ref <= 1'b1; m_busy <= REFR + 1;
      end else begin
        m_v <= cand; m_spk <= 1'b0; m_ref <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_potential", int'(potential), m_v);
      check("cyc_spike_out", int'(spike_out), int'(m_spk));
      check("cyc_refractory", int'(refractory), int'(m_ref));
    end
  end

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    weight[0] = W'(w0); weight[1] = W'(w1); weight[2] = W'(w2); weight[3] = W'(w3);
  endtask

  initial begin
    reset = 1'b0;
    dendrite_spike = '0;
    set_weights(0, 0, 0, 0);

    // Reset held two cycles, then idle with no spikes.
    tick(2);
    chk_en = 1'b1;
    check("rst_potential", int'(potential), 0);
    check("rst_spike_out", int'(spike_out), 0);
    check("rst_refractory", int'(refractory), 0);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("idle_potential", int'(potential), 0);
      check("idle_refractory", int'(refractory), 0);
    end

    // Constant weight-60 drive: fire on the 2nd edge, then again 6 cycles later.
    set_weights(60, 0, 0, 0);
    dendrite_spike = 4'b0001;
    tick(1); check("drv_edge1_potential", int'(potential), 60);
    tick(1); check("drv_fire_spike", int'(spike_out), 1);
             check("drv_fire_potential", int'(potential), 0);
             check("drv_fire_refractory", int'(refractory), 1);
    tick(1); check("drv_refr1_spike", int'(spike_out), 0);
             check("drv_refr1_refractory", int'(refractory), 1);
    tick(2); check("drv_refr3_refractory", int'(refractory), 1);
    tick(1); check("drv_resume_refractory", int'(refractory), 0);
             check("drv_resume_dropped", int'(potential), 0);
    tick(1); check("drv_reint_potential", int'(potential), 60);
    tick(1); check("drv_second_fire", int'(spike_out), 1);
    dendrite_spike = '0;
    reset = 1'b0; tick(1); reset = 1'b1;

    // Four simultaneous spikes of 30 fire in a single step.
    set_weights(30, 30, 30, 30);
    dendrite_spike = 4'b1111;
    tick(1); check("all4_spike", int'(spike_out), 1);
             check("all4_potential", int'(potential), 0);
    dendrite_spike = '0;
    tick(4); check("all4_recovered", int'(refractory), 0);

    // Preload 5 then leak down to 0 and hold.
    set_weights(5, 0, 0, 0);
    dendrite_spike = 4'b0001;
    tick(1); check("leak_preload", int'(potential), 5);
    dendrite_spike = '0;
    for (int k = 4; k >= 0; k--) begin
      tick(1); check("leak_step", int'(potential), k);
    end
    tick(3); check("leak_hold_zero", int'(potential), 0);

    // Negative saturation without wrap, then leak back up by 1 per cycle.
    set_weights(0, -50, 0, 0);
    dendrite_spike = 4'b0010;
    tick(1000); check("neg_saturated", int'(potential), -32768);
    dendrite_spike = '0;
    tick(1); check("neg_leak1", int'(potential), -32767);
    tick(1); check("neg_leak2", int'(potential), -32766);

    // Reset asserted in the second refractory cycle.
    reset = 1'b0; tick(1); reset = 1'b1;
    set_weights(60, 0, 0, 0);
    dendrite_spike = 4'b0001;
    tick(2); check("mid_fire_spike", int'(spike_out), 1);
    tick(2); check("mid_refr2_refractory", int'(refractory), 1);
    reset = 1'b0;
    tick(1); check("mid_rst_refractory", int'(refractory), 0);
             check("mid_rst_potential", int'(potential), 0);
             check("mid_rst_spike", int'(spike_out), 0);
    reset = 1'b1;
    tick(1); check("mid_rst_integrate", int'(potential), 60);
    dendrite_spike = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
